// File: rtl/fifo_pixel_unpacker_if.sv
// Pixel stream from the unpacker to the display/processing stage.
// Carries the pixel, its raster coordinates and the line/frame markers.
interface fifo_pixel_unpacker_if #(
  parameter int unsigned PIXEL_SIZE = 8,
  parameter int unsigned X_W        = 10,
  parameter int unsigned Y_W        = 9
);
  logic [PIXEL_SIZE-1:0] pix_data;
  logic                  pix_valid;
  logic                  pix_ready;
  logic [X_W-1:0]        pix_x;
  logic [Y_W-1:0]        pix_y;
  logic                  pix_sof;
  logic                  pix_eol;
  logic                  pix_eof;

  modport master (
    output pix_data, pix_valid, pix_x, pix_y, pix_sof, pix_eol, pix_eof,
    input  pix_ready
  );

  modport slave (
    input  pix_data, pix_valid, pix_x, pix_y, pix_sof, pix_eol, pix_eof,
    output pix_ready
  );
endinterface

// File: rtl/fifo_pixel_unpacker.sv
// Pops 32-bit words from a show-ahead FIFO and streams them out as four
// LSB-first pixels with raster position, markers and a mid-frame underrun count.
module fifo_pixel_unpacker #(
  parameter int unsigned DATA_SIZE   = 32,
  parameter int unsigned PIXEL_SIZE  = 8,
  parameter int unsigned LINE_WIDTH  = 640,
  parameter int unsigned FRAME_LINES = 480,
  parameter int unsigned CNT_SIZE    = 16
) (
  input  logic                  clk,
  input  logic                  nRST,
  input  logic [DATA_SIZE-1:0]  fifo_data,
  input  logic                  fifo_empty,
  output logic                  r_ack,
  fifo_pixel_unpacker_if.master pix,
  output logic [CNT_SIZE-1:0]   underrun_cnt
);
  localparam int unsigned X_W = $clog2(LINE_WIDTH);
  localparam int unsigned Y_W = $clog2(FRAME_LINES);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                      state;
  logic [3:0][PIXEL_SIZE-1:0]  word;
  logic [1:0]                  idx;
  logic [X_W-1:0]              x;
  logic [Y_W-1:0]              y;

  logic fetch;
  logic xfer;
  logic last_x;
  logic last_y;
  logic starved;

  // A new word is taken when nothing is held or the last byte leaves this cycle,
  // which keeps the stream gap-free across word boundaries.
  assign fetch   = !fifo_empty &&
                   ((state == EMPTY) || ((state == FULL) && (idx == 2'd3) && pix.pix_ready));
  assign r_ack   = fetch;
  assign xfer    = (state == FULL) && pix.pix_ready;
  assign last_x  = (x == X_W'(LINE_WIDTH - 1));
  assign last_y  = (y == Y_W'(FRAME_LINES - 1));
  assign starved = (state == EMPTY) && fifo_empty && !((x == '0) && (y == '0));

  assign pix.pix_valid = (state == FULL);
  assign pix.pix_data  = word[idx];
  assign pix.pix_x     = x;
  assign pix.pix_y     = y;
  assign pix.pix_sof   = (x == '0) && (y == '0);
  assign pix.pix_eol   = last_x;
  assign pix.pix_eof   = last_x && last_y;

  always_ff @(posedge clk) begin
    if (nRST) begin
      state        <= EMPTY;
      word         <= '0;
      idx          <= '0;
      x            <= '0;
      y            <= '0;
      underrun_cnt <= '0;
    end else begin
      if (fetch) begin
        word  <= fifo_data;
        idx   <= '0;
        state <= FULL;
      end else if (xfer) begin
        if (idx == 2'd3) begin
          state <= EMPTY;
        end else begin
          idx <= idx + 2'd1;
        end
      end

      // Raster position advances only on an accepted pixel.
      if (xfer) begin
        if (last_x) begin
          x <= '0;
          y <= last_y ? '0 : y + Y_W'(1);
        end else begin
          x <= x + X_W'(1);
        end
      end

      if (starved && (underrun_cnt != '1)) begin
        underrun_cnt <= underrun_cnt + CNT_SIZE'(1);
      end
    end
  end
endmodule

// File: tb/tb_fifo_pixel_unpacker.sv
// Directed bench for fifo_pixel_unpacker with an 8x2 raster: a vector table
// for fetch/unpack/reset timing, then streamed sequences checked against a FIFO model.
module tb_fifo_pixel_unpacker;
  localparam int unsigned LW = 8;
  localparam int unsigned FL = 2;

  logic        clk = 1'b0;
  logic        nRST;
  logic [31:0] fifo_data;
  logic        fifo_empty;
  logic        r_ack;
  logic [15:0] underrun_cnt;

  fifo_pixel_unpacker_if #(.PIXEL_SIZE(8), .X_W(3), .Y_W(1)) pix_if ();

  fifo_pixel_unpacker #(
    .DATA_SIZE(32), .PIXEL_SIZE(8), .LINE_WIDTH(LW), .FRAME_LINES(FL), .CNT_SIZE(16)
  ) dut (
    .clk(clk), .nRST(nRST), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .r_ack(r_ack), .pix(pix_if), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        empty;
    logic [31:0] data;
    logic        ready;
    logic        ack;
    logic        valid;
    logic [7:0]  pd;
    logic [2:0]  x;
    logic        y;
    logic        sof;
    logic [15:0] und;
  } vec_t;

  vec_t tbl[13];

  // FIFO model and stream scoreboard state
  logic [31:0] fq[$];
  logic [7:0]  exp_bytes[$];
  bit          rdy;
  int          k;
  int          cyc, first_xfer, last_xfer, n_ack, n_eol, n_eof, n_sof;
  bit          prev_stall;
  logic [7:0]  prev_data;
  logic [2:0]  prev_x;

  task automatic do_reset();
    nRST       = 1'b1;
    fifo_empty = 1'b1;
    fifo_data  = 32'h0;
    pix_if.pix_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nRST = 1'b0;
    fq.delete();
    exp_bytes.delete();
    k = 0; cyc = 0; first_xfer = -1; last_xfer = -1;
    n_ack = 0; n_eol = 0; n_eof = 0; n_sof = 0;
    prev_stall = 1'b0;
    rdy = 1'b1;
  endtask

  task automatic push_word(input logic [31:0] w);
    fq.push_back(w);
    for (int b = 0; b < 4; b++) exp_bytes.push_back(8'(w >> (8 * b)));
  endtask

  task automatic tick();
    bit exp_ack, do_ack, xfer;
    logic [7:0] eb;
    fifo_empty       = (fq.size() == 0);
    fifo_data        = fifo_empty ? 32'h0 : fq[0];
    pix_if.pix_ready = rdy;
    #1;
    exp_ack = !fifo_empty && (!pix_if.pix_valid || ((k % 4 == 3) && rdy));
    chk("r_ack", 32'(r_ack), 32'(exp_ack));
    if (prev_stall) begin
      chk("hold_data", 32'(pix_if.pix_data), 32'(prev_data));
      chk("hold_x", 32'(pix_if.pix_x), 32'(prev_x));
    end
    xfer = pix_if.pix_valid && rdy;
    if (xfer) begin
      eb = (exp_bytes.size() != 0) ? exp_bytes.pop_front() : 8'hxx;
      chk("pix_data", 32'(pix_if.pix_data), 32'(eb));
      chk("pix_x", 32'(pix_if.pix_x), 32'(k % LW));
      chk("pix_y", 32'(pix_if.pix_y), 32'((k / LW) % FL));
      chk("pix_sof", 32'(pix_if.pix_sof), 32'(k % (LW * FL) == 0));
      chk("pix_eol", 32'(pix_if.pix_eol), 32'(k % LW == LW - 1));
      chk("pix_eof", 32'(pix_if.pix_eof), 32'(k % (LW * FL) == LW * FL - 1));
      if (first_xfer < 0) first_xfer = cyc;
      last_xfer = cyc;
      if (pix_if.pix_eol) n_eol++;
      if (pix_if.pix_eof) n_eof++;
      if (pix_if.pix_sof) n_sof++;
    end
    prev_stall = pix_if.pix_valid && !rdy;
    prev_data  = pix_if.pix_data;
    prev_x     = pix_if.pix_x;
    do_ack     = r_ack;
    if (do_ack) n_ack++;
    @(posedge clk);
    if (do_ack && fq.size() != 0) fq.delete(0);
    if (xfer) k++;
    cyc++;
    #1;
  endtask

  task automatic run_until(input string name, input int target, input bit toggle);
    int n = 0;
    while (k < target && n < 400) begin
      if (toggle) rdy = ~rdy;
      tick();
      n++;
    end
    rdy = 1'b1;
    chk(name, 32'(k), 32'(target));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          rst   emp   data          rdy   ack   vld   pd     x     y     sof   und
    tbl[0]  = '{1'b0, 1'b0, 32'h44332211, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 16'd0};
    tbl[1]  = '{1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b1, 8'h11, 3'd0, 1'b0, 1'b1, 16'd0};
    tbl[2]  = '{1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b1, 8'h22, 3'd1, 1'b0, 1'b0, 16'd0};
    tbl[3]  = '{1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b1, 8'h33, 3'd2, 1'b0, 1'b0, 16'd0};
    tbl[4]  = '{1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b1, 8'h44, 3'd3, 1'b0, 1'b0, 16'd0};
    tbl[5]  = '{1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0, 16'd0};
    tbl[6]  = '{1'b0, 1'b0, 32'h44332211, 1'b1, 1'b1, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0, 16'd1};
    tbl[7]  = '{1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b1, 8'h11, 3'd4, 1'b0, 1'b0, 16'd1};
    tbl[8]  = '{1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b1, 8'h22, 3'd5, 1'b0, 1'b0, 16'd1};
    tbl[9]  = '{1'b1, 1'b1, 32'h0,        1'b1, 1'b0, 1'b1, 8'h33, 3'd6, 1'b0, 1'b0, 16'd1};
    tbl[10] = '{1'b0, 1'b0, 32'hAABBCCDD, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 16'd0};
    tbl[11] = '{1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b1, 8'hDD, 3'd0, 1'b0, 1'b1, 16'd0};
    tbl[12] = '{1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b1, 8'hCC, 3'd1, 1'b0, 1'b0, 16'd0};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      nRST             = tbl[i].rst;
      fifo_empty       = tbl[i].empty;
      fifo_data        = tbl[i].data;
      pix_if.pix_ready = tbl[i].ready;
      #1;
      chk($sformatf("v%0d_ack", i), 32'(r_ack), 32'(tbl[i].ack));
      chk($sformatf("v%0d_valid", i), 32'(pix_if.pix_valid), 32'(tbl[i].valid));
      if (tbl[i].valid)
        chk($sformatf("v%0d_data", i), 32'(pix_if.pix_data), 32'(tbl[i].pd));
      chk($sformatf("v%0d_x", i), 32'(pix_if.pix_x), 32'(tbl[i].x));
      chk($sformatf("v%0d_y", i), 32'(pix_if.pix_y), 32'(tbl[i].y));
      chk($sformatf("v%0d_sof", i), 32'(pix_if.pix_sof), 32'(tbl[i].sof));
      chk($sformatf("v%0d_und", i), 32'(underrun_cnt), 32'(tbl[i].und));
      @(posedge clk);
      #1;
    end

    // Back-to-back: 20 words, 80 pixels, 5 frames of 8x2
    do_reset();
    for (int w = 0; w < 20; w++)
      push_word({8'(4 * w + 3), 8'(4 * w + 2), 8'(4 * w + 1), 8'(4 * w)});
    run_until("b2b_done", 80, 1'b0);
    chk("b2b_span", 32'(last_xfer - first_xfer + 1), 32'd80);
    chk("b2b_acks", 32'(n_ack), 32'd20);
    chk("b2b_eol", 32'(n_eol), 32'd10);
    chk("b2b_eof", 32'(n_eof), 32'd5);
    chk("b2b_sof", 32'(n_sof), 32'd5);
    chk("b2b_und", 32'(underrun_cnt), 32'd0);

    // Backpressure: ready toggles every cycle
    do_reset();
    for (int w = 0; w < 6; w++) push_word(32'hA0B0C0D0 + 32'(w * 32'h01010101));
    run_until("bp_done", 24, 1'b1);
    chk("bp_acks", 32'(n_ack), 32'd6);

    // Underrun mid-frame counts, starvation at the frame boundary does not
    do_reset();
    push_word(32'h04030201);
    run_until("ur_first", 4, 1'b0);
    repeat (10) tick();
    chk("ur_mid", 32'(underrun_cnt), 32'd10);
    chk("ur_ack_starved", 32'(n_ack), 32'd1);
    for (int w = 0; w < 3; w++) push_word(32'h14131211 + 32'(w * 32'h10101010));
    run_until("ur_frame", 16, 1'b0);
    chk("ur_after_frame", 32'(underrun_cnt), 32'd10);
    repeat (10) tick();
    chk("ur_boundary", 32'(underrun_cnt), 32'd10);
    push_word(32'hDEADBEEF);
    run_until("ur_next", 20, 1'b0);
    chk("ur_final", 32'(underrun_cnt), 32'd10);
    chk("ur_sof_count", 32'(n_sof), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_pixel_unpacker.md
Name: fifo_pixel_unpacker

Overview:
- Downstream consumer of the 32-bit pixel FIFO.
- Pops words from the FIFO head and splits each word into four 8-bit pixels.
- Emits the pixels on a valid/ready stream, with raster coordinates and start/end-of-line/frame markers, to the display/processing stage.
- Counts starvation cycles inside a frame for debug.

Parameters:
- DATA_SIZE, 32: FIFO word width; must equal PIXEL_SIZE*4.
- PIXEL_SIZE, 8: output pixel width.
- LINE_WIDTH, 640: pixels per line; must be a multiple of 4.
- FRAME_LINES, 480: lines per frame.
- CNT_SIZE, 16: width of the underrun counter.

Ports:
- clk  in  1  system clock, rising edge.
- nRST  in  1  synchronous, active-high reset.
- fifo_data  in  DATA_SIZE  FIFO head word, show-ahead (valid whenever fifo_empty=0).
- fifo_empty  in  1  FIFO has no word.
- r_ack  out  1  one-cycle pop strobe to the FIFO; the head word is consumed at this clock edge.
- pix_data  out  PIXEL_SIZE  current pixel.
- pix_valid  out  1  pix_data and its sideband are valid.
- pix_ready  in  1  consumer accepts; transfer = pix_valid & pix_ready.
- pix_x  out  clog2(LINE_WIDTH)  column of the current pixel.
- pix_y  out  clog2(FRAME_LINES)  line of the current pixel.
- pix_sof  out  1  pix_x=0 and pix_y=0.
- pix_eol  out  1  pix_x=LINE_WIDTH-1.
- pix_eof  out  1  last pixel of the frame.
- underrun_cnt  out  CNT_SIZE  saturating count of mid-frame starvation cycles.

Behaviour:
- Reset (nRST=1 at a clock edge, any state):
  - word register cleared; byte index=0; state EMPTY.
  - pix_valid=0, r_ack=0, pix_data=0, pix_x=0, pix_y=0, underrun_cnt=0.
  - Any word already popped but not fully emitted is discarded.
- States:
  - EMPTY: no word held.
  - FULL: word held, byte index 0..3.
- Fetch condition: fetch = !fifo_empty & (state==EMPTY | (state==FULL & idx==3 & pix_ready)).
  - r_ack = fetch, driven combinationally from registered state plus inputs.
  - fifo_data is captured into the word register at the same edge; idx<=0; state<=FULL.
- Transitions:
  - EMPTY -> FULL on fetch.
  - FULL stays FULL while bytes remain.
  - FULL with idx==3 and a transfer: -> FULL (new word) if fetch, else -> EMPTY.
- Output:
  - pix_valid = (state==FULL).
  - pix_data = word[idx*PIXEL_SIZE +: PIXEL_SIZE]; byte 0 (LSB) is emitted first.
  - pix_data and sideband stay stable while pix_valid & !pix_ready.
- Latency: word present at edge N with EMPTY state -> r_ack during cycle N -> first pixel valid in cycle N+1.
- Throughput: sustained 1 pixel/cycle with no bubble between words when the FIFO stays non-empty and pix_ready=1.
- Counters (advance only on a transfer):
  - pix_x increments and wraps LINE_WIDTH-1 -> 0.
  - On that wrap, pix_y increments and wraps FRAME_LINES-1 -> 0.
  - sof/eol/eof are derived combinationally from pix_x/pix_y.
- Underrun:
  - Increments in each cycle where state==EMPTY & fifo_empty & !(pix_x==0 & pix_y==0), i.e. starved mid-frame.
  - Saturates at all-ones.
  - Cleared only by reset.
  - Starvation at the frame boundary is not counted.
- fifo_empty=1 while state==EMPTY: r_ack stays 0; FIFO is never popped when empty.
- pix_ready=0 during the last byte: no fetch, even if the FIFO is non-empty.

Test Plan:
- Reset mid-stream:
  - Stimulus: load word 0x44332211, take 2 pixels, then assert nRST for 1 cycle.
  - Required: pix_valid=0, pix_x=0, underrun_cnt=0 the next cycle; the remaining bytes 0x33/0x44 are never emitted.
- Basic unpack:
  - Stimulus: FIFO holds 0x44332211, pix_ready=1.
  - Required: r_ack pulses one cycle; then pix_data 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles with pix_x 0..3; pix_sof=1 on the first pixel only.
- Back-to-back:
  - Stimulus: 20 sequential words 0,1,2,... in the FIFO, pix_ready=1.
  - Required: 80 pixels in 80 consecutive cycles; r_ack high exactly in the cycle of each word's 4th byte (plus the initial fetch); no gap.
- Backpressure:
  - Stimulus: toggle pix_ready 0/1 every cycle.
  - Required: pix_data and pix_x hold while ready=0; r_ack is never asserted while ready=0 on the last byte; the pixel sequence is unchanged.
- Line/frame wrap:
  - Stimulus: LINE_WIDTH=8, FRAME_LINES=2, stream 5 words.
  - Required: pix_eol at pixels 7 and 15; pix_eof at pixel 15; pixel 16 has pix_x=0, pix_y=0, pix_sof=1.
- Underrun:
  - Stimulus: after 1 word (4 pixels), hold fifo_empty=1 for 10 cycles, then supply a word.
  - Required: underrun_cnt=10, or 9 if the first empty cycle is the 4th-byte cycle (still FULL); no r_ack during starvation. Repeating after a frame-end wrap leaves the counter unchanged.
